// File: rtl/ps2_key_encoder.sv
// rtl/ps2_key_encoder.sv - PS/2 set-2 keyboard deserialiser producing the 11-bit ps2_key event word.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of the held key.
module ps2_key_encoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 60000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // index 0 = ps2_clk, index 1 = ps2_data
    logic [1:0]     sync1_q, sync2_q, filt_q;
    logic [FCW-1:0] fcnt_q [2];
    logic           clk_prev_q;

    state_t         state_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shift_q;
    logic           par_q;
    logic [WDW-1:0] wd_q;
    logic           ext_q, brk_q;
    logic [2:0]     skip_q;
    logic [10:0]    key_q;
    logic           ferr_q;
    logic [7:0]     errcnt_q;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0]     held_q;
    logic           held_v_q;
`endif

    logic fall, sampled, err_d, byte_ok, emit_d;

    assign fall    = clk_prev_q & ~filt_q[0];
    assign sampled = filt_q[1];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q[0]  <= '0;
            fcnt_q[1]  <= '0;
            clk_prev_q <= 1'b1;
        end else begin
            sync1_q    <= {ps2_data, ps2_clk};
            sync2_q    <= sync1_q;
            clk_prev_q <= filt_q[0];
            // Level only moves after FILTER_LEN consecutive disagreeing samples.
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FCW'(1);
                end
            end
        end
    end

    always_comb begin
        err_d   = 1'b0;
        byte_ok = 1'b0;
        if (fall) begin
            case (state_q)
                ST_IDLE: err_d = sampled;
                ST_STOP: begin
                    if (sampled && (^{shift_q, par_q})) byte_ok = 1'b1;
                    else                                err_d   = 1'b1;
                end
                default: ;
            endcase
        end else if (state_q != ST_IDLE && wd_q == WDW'(TIMEOUT_CYC - 1)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        emit_d = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (!brk_q && held_v_q && held_q == {ext_q, shift_q}) emit_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            wd_q      <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            skip_q    <= '0;
            key_q     <= '0;
            ferr_q    <= 1'b0;
            errcnt_q  <= '0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held_q    <= '0;
            held_v_q  <= 1'b0;
`endif
        end else begin
            ferr_q <= err_d;
            if (err_d && errcnt_q != 8'd255) errcnt_q <= errcnt_q + 8'd1;

            if (fall) begin
                wd_q <= '0;
                case (state_q)
                    ST_IDLE: begin
                        if (!sampled) begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q <= {sampled, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) state_q <= ST_PARITY;
                        else                   bit_idx_q <= bit_idx_q + 3'd1;
                    end
                    ST_PARITY: begin
                        par_q   <= sampled;
                        state_q <= ST_STOP;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE) begin
                if (err_d) begin
                    state_q <= ST_IDLE;
                    wd_q    <= '0;
                end else begin
                    wd_q <= wd_q + WDW'(1);
                end
            end

            if (err_d) begin
                ext_q  <= 1'b0;
                brk_q  <= 1'b0;
                skip_q <= '0;
            end else if (byte_ok) begin
                if (skip_q != 3'd0) begin
                    skip_q <= skip_q - 3'd1;
                end else if (shift_q == 8'hE1) begin
                    skip_q <= 3'd7;
                end else if (shift_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    if (emit_d) key_q <= {~key_q[10], ~brk_q, ext_q, shift_q};
`ifdef PS2_TYPEMATIC_FILTER_EN
                    if (brk_q) begin
                        if (held_q == {ext_q, shift_q}) held_v_q <= 1'b0;
                    end else begin
                        held_q   <= {ext_q, shift_q};
                        held_v_q <= 1'b1;
                    end
`endif
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = ferr_q;
    assign err_cnt   = errcnt_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb/tb_ps2_key_encoder.sv - self-checking bench for ps2_key_encoder with a byte-level reference model.
module tb_ps2_key_encoder;

    localparam int FL   = 4;
    localparam int TO   = 400;
    localparam int HALF = 12;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic [7:0]  err_cnt;

    ps2_key_encoder #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Error pulse monitor: every error must show as an isolated one-cycle pulse.
    int   ferr_cycles = 0;
    int   ferr_double = 0;
    logic ferr_prev = 1'b0;
    always @(negedge clk_sys) begin
        if (frame_err) ferr_cycles++;
        if (frame_err && ferr_prev) ferr_double++;
        ferr_prev = frame_err;
    end

    // Reference model at the level of whole bytes.
    logic [10:0] m_key;
    logic [7:0]  m_errcnt;
    int          m_err_total;
    bit          m_ext, m_brk;
    int          m_skip;
    logic [8:0]  m_held;
    bit          m_held_v;

    task automatic model_reset();
        m_key = '0; m_errcnt = '0; m_ext = 0; m_brk = 0; m_skip = 0;
        m_held = '0; m_held_v = 0;
    endtask

    task automatic model_err();
        m_err_total++;
        if (m_errcnt < 8'd255) m_errcnt = m_errcnt + 8'd1;
        m_ext = 0; m_brk = 0; m_skip = 0;
    endtask

    task automatic model_byte(input logic [7:0] c, input bit bad);
        bit emit;
        if (bad) begin
            model_err();
            return;
        end
        if (m_skip != 0) m_skip--;
        else if (c == 8'hE1) m_skip = 7;
        else if (c == 8'hE0) m_ext = 1;
        else if (c == 8'hF0) m_brk = 1;
        else begin
            emit = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!m_brk && m_held_v && m_held == {m_ext, c}) emit = 0;
            else if (m_brk) begin
                if (m_held_v && m_held == {m_ext, c}) m_held_v = 0;
            end else begin
                m_held = {m_ext, c};
                m_held_v = 1;
            end
`endif
            if (emit) m_key = {~m_key[10], ~m_brk, m_ext, c};
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit badpar, input bit badstop);
        logic p;
        p = (~^code) ^ badpar;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(p);
        send_bit(~badstop);
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);
        model_byte(code, badpar | badstop);
    endtask

    task automatic send_start_err();
        ps2_data = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(HALF);
        model_err();
    endtask

    task automatic check_model(input string name);
        @(negedge clk_sys);
        check({name, ".key"}, {21'd0, ps2_key}, {21'd0, m_key});
        check({name, ".err_cnt"}, {24'd0, err_cnt}, {24'd0, m_errcnt});
    endtask

    typedef struct {
        logic [7:0]  code;
        bit          bad;
        logic [10:0] key;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t tbl [6];

    int toggles;
    int exp_toggles;
    logic t_prev;
    logic [10:0] key_before;
    logic [7:0]  cnt_before;

    initial begin
        tbl[0] = '{8'h1C, 1'b0, 11'h61C, 8'd0};
        tbl[1] = '{8'hE0, 1'b0, 11'h61C, 8'd0};
        tbl[2] = '{8'hF0, 1'b0, 11'h61C, 8'd0};
        tbl[3] = '{8'h75, 1'b0, 11'h175, 8'd0};
        tbl[4] = '{8'h29, 1'b1, 11'h175, 8'd1};
        tbl[5] = '{8'h29, 1'b0, 11'h629, 8'd1};

        model_reset();
        m_err_total = 0;
        wait_cyc(4);
        @(negedge clk_sys);
        check("reset.key", {21'd0, ps2_key}, 32'd0);
        check("reset.frame_err", {31'd0, frame_err}, 32'd0);
        check("reset.err_cnt", {24'd0, err_cnt}, 32'd0);
        reset_n = 1'b1;
        wait_cyc(20);
        check_model("post_reset");

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].code, tbl[i].bad, 1'b0);
            @(negedge clk_sys);
            check($sformatf("tbl%0d.key", i), {21'd0, ps2_key}, {21'd0, tbl[i].key});
            check($sformatf("tbl%0d.err_cnt", i), {24'd0, err_cnt}, {24'd0, tbl[i].ecnt});
            check_model($sformatf("tbl%0d.model", i));
        end

        // Clock stalls after four data bits.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        ps2_data = 1'b1;
        wait_cyc(TO + 100);
        model_err();
        check_model("timeout");
        check("timeout.err_cnt", {24'd0, err_cnt}, 32'd2);
        send_frame(8'h14, 1'b0, 1'b0);
        @(negedge clk_sys);
        check("after_timeout.key", {21'd0, ps2_key}, 32'h214);
        check_model("after_timeout");

        // Typematic repeats of 0x1D with one break in the middle.
        toggles = 0;
        t_prev = ps2_key[10];
        foreach (tbl[0].code[k]) begin end
        for (int i = 0; i < 6; i++) begin
            logic [7:0] seq_b;
            case (i)
                3:       seq_b = 8'hF0;
                default: seq_b = 8'h1D;
            endcase
            send_frame(seq_b, 1'b0, 1'b0);
            @(negedge clk_sys);
            if (ps2_key[10] != t_prev) toggles++;
            t_prev = ps2_key[10];
            check_model($sformatf("typematic%0d", i));
        end
`ifdef PS2_TYPEMATIC_FILTER_EN
        exp_toggles = 3;
`else
        exp_toggles = 5;
`endif
        check("typematic.toggles", toggles, exp_toggles);

        // Pause sequence.
        key_before = ps2_key;
        cnt_before = err_cnt;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] pb;
            case (i)
                0, 3:    pb = 8'hE1;
                1, 5:    pb = 8'h14;
                2, 7:    pb = 8'h77;
                default: pb = 8'hF0;
            endcase
            send_frame(pb, 1'b0, 1'b0);
        end
        @(negedge clk_sys);
        check("pause.key", {21'd0, ps2_key}, {21'd0, key_before});
        check("pause.err_cnt", {24'd0, err_cnt}, {24'd0, cnt_before});
        check_model("pause");

        // Randomised traffic with occasional prefixes and corrupted frames.
        for (int i = 0; i < 40; i++) begin
            int r;
            logic [7:0] c;
            bit bp, bs;
            r = $urandom_range(0, 11);
            case (r)
                0:       c = 8'hE0;
                1:       c = 8'hF0;
                2:       c = 8'hE1;
                3, 4:    c = 8'h1D;
                default: c = 8'($urandom_range(1, 127));
            endcase
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 14) == 0);
            send_frame(c, bp, bs);
            check_model($sformatf("rand%0d", i));
        end

        // Saturate the error counter.
        key_before = ps2_key;
        for (int i = 0; i < 260; i++) send_start_err();
        @(negedge clk_sys);
        check("sat.err_cnt", {24'd0, err_cnt}, 32'd255);
        check("sat.key", {21'd0, ps2_key}, {21'd0, key_before});
        check_model("sat");
        check("err_pulse.cycles", ferr_cycles, m_err_total);
        check("err_pulse.width", ferr_double, 0);

        // Reset in the middle of a frame.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset_n = 1'b0;
        ps2_data = 1'b1;
        wait_cyc(3);
        @(negedge clk_sys);
        check("midreset.key", {21'd0, ps2_key}, 32'd0);
        check("midreset.err_cnt", {24'd0, err_cnt}, 32'd0);
        model_reset();
        reset_n = 1'b1;
        wait_cyc(20);
        send_frame(8'h1C, 1'b0, 1'b0);
        @(negedge clk_sys);
        check("after_reset.key", {21'd0, ps2_key}, 32'h61C);
        check_model("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "time limit");
    end

endmodule
